// File: rtl/cmd_word_decoder.sv
// Command-word receiver: decodes cmd_icd_pkg words into bank-register writes or
// forwarded OUT fields, dropping and counting malformed words.
module cmd_word_decoder #(
  parameter bit          STRICT_RSVD  = 1'b1,
  parameter logic [7:0]  BANK_RST_VAL = 8'h00,
  parameter int unsigned ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          s_data_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  output logic [31:0]          bank_val_o,
  output logic [3:0]           bank_upd_o,
  output logic [4:0]           out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 err_o,
  output logic [1:0]           err_code_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    OUT_WAIT
  } state_t;

  state_t          state, state_nxt;
  logic [31:0]     word_q;
  logic [3:0][7:0] bank_q;

  logic       id_bank, id_out;
  logic       rsvd_bank, rsvd_out;
  logic [1:0] dec_code;
  logic       exec_bank, exec_out, exec_err;

  // Unknown ID outranks any reserved-field violation.
  always_comb begin
    id_bank   = (word_q[31:28] == 4'b0000);
    id_out    = (word_q[31:28] == 4'b0001);
    rsvd_bank = (|word_q[7:4]) | (|word_q[27:16]);
    rsvd_out  = |word_q[27:5];
    dec_code  = 2'd0;
    if (!id_bank && !id_out)
      dec_code = 2'd1;
    else if (STRICT_RSVD && ((id_bank && rsvd_bank) || (id_out && rsvd_out)))
      dec_code = 2'd2;
    exec_err  = (state == EXEC) && (dec_code != 2'd0);
    exec_bank = (state == EXEC) && (dec_code == 2'd0) && id_bank;
    exec_out  = (state == EXEC) && (dec_code == 2'd0) && id_out;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (s_valid_i) state_nxt = EXEC;
      EXEC:     state_nxt = exec_out ? OUT_WAIT : IDLE;
      OUT_WAIT: if (out_ready_i) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q      <= '0;
      bank_q      <= {4{BANK_RST_VAL}};
      bank_upd_o  <= '0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= '0;
      err_cnt_o   <= '0;
    end else begin
      bank_upd_o <= '0;
      err_o      <= 1'b0;
      if (state == IDLE && s_valid_i)
        word_q <= s_data_i;
      if (exec_bank) begin
        for (int unsigned i = 0; i < 4; i++)
          if (word_q[i]) bank_q[i] <= word_q[15:8];
        bank_upd_o <= word_q[3:0];
      end
      if (exec_out) begin
        out_data_o  <= word_q[4:0];
        out_valid_o <= 1'b1;
      end else if (state == OUT_WAIT && out_ready_i) begin
        out_valid_o <= 1'b0;
      end
      if (exec_err) begin
        err_o      <= 1'b1;
        err_code_o <= dec_code;
        if (err_cnt_o != '1)
          err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
      end
    end
  end

  assign bank_val_o = bank_q;
  assign s_ready_o  = (state == IDLE);
  assign busy_o     = (state != IDLE);

endmodule
